sram_rw_port_arbiter: RTL and testbench

- Owns the 1RW port (port 0) of the 32x256 OpenRAM macro and shares it between two requesters: A (fabric side) and B (Wishbone/management side).
- Runs a zero-fill sweep of the whole array after reset.
- Arbitrates round-robin, registers all SRAM control outputs, and returns read data with a fixed 2-cycle latency.
- The read-only port (port 1) is outside this block.

---
 rtl/sram_rw_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_sram_rw_port_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_rw_port_arbiter.sv
// Two-requester arbiter for the 1RW port of the 32x256 OpenRAM macro.
// After reset it zero-fills the array. In RUN it grants round-robin and
// registers all SRAM controls. Read data comes back on a shared bus two
// cycles after the accept edge, tagged with the requester that issued it.
module sram_rw_port_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned NUM_WMASKS     = 4,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  // Requester A
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [NUM_WMASKS-1:0] a_req_wmask,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  // Requester B
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [NUM_WMASKS-1:0] b_req_wmask,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  // Responses
  output logic                  a_rsp_valid,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  // SRAM port 0
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   clr_addr_q;
  logic                    init_done_q;
  logic                    ptr_q;  // 0 = A wins a tie, 1 = B wins a tie

  logic                    csb_q;
  logic                    web_q;
  logic [NUM_WMASKS-1:0]   wmask_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   din_q;

  // Response tag pipeline: stage 1 while SRAM samples, stage 2 while dout settles
  logic                    s1_rd_q, s1_id_q;
  logic                    s2_rd_q, s2_id_q;

  logic                    a_rsp_valid_q;
  logic                    b_rsp_valid_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;

  logic                    grant_a, grant_b, accept;
  logic                    sel_we;
  logic [NUM_WMASKS-1:0]   sel_wmask;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  // Round-robin grant and request mux; init_done_q is only set in RUN
  always_comb begin
    grant_a   = init_done_q & a_req_valid & (~b_req_valid | ~ptr_q);
    grant_b   = init_done_q & b_req_valid & (~a_req_valid | ptr_q);
    accept    = grant_a | grant_b;
    sel_we    = grant_b ? b_req_we    : a_req_we;
    sel_wmask = grant_b ? b_req_wmask : a_req_wmask;
    sel_addr  = grant_b ? b_req_addr  : a_req_addr;
    sel_wdata = grant_b ? b_req_wdata : a_req_wdata;
  end

  // FSM, SRAM control registers, response pipeline and read-data capture
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q       <= (CLEAR_ON_RESET != 0) ? StClear : StRun;
      clr_addr_q    <= '0;
      init_done_q   <= 1'b0;
      ptr_q         <= 1'b0;
      csb_q         <= 1'b1;
      web_q         <= 1'b1;
      wmask_q       <= '0;
      addr_q        <= '0;
      din_q         <= '0;
      s1_rd_q       <= 1'b0;
      s1_id_q       <= 1'b0;
      s2_rd_q       <= 1'b0;
      s2_id_q       <= 1'b0;
      a_rsp_valid_q <= 1'b0;
      b_rsp_valid_q <= 1'b0;
      rsp_rdata_q   <= '0;
    end else begin
      s1_rd_q       <= accept & ~sel_we;
      s1_id_q       <= grant_b;
      s2_rd_q       <= s1_rd_q;
      s2_id_q       <= s1_id_q;
      a_rsp_valid_q <= s2_rd_q & ~s2_id_q;
      b_rsp_valid_q <= s2_rd_q & s2_id_q;
      if (s2_rd_q) begin
        rsp_rdata_q <= sram_dout0;
      end

      unique case (state_q)
        StClear: begin
          csb_q      <= 1'b0;
          web_q      <= 1'b0;
          wmask_q    <= '1;
          din_q      <= '0;
          addr_q     <= clr_addr_q;
          clr_addr_q <= clr_addr_q + 1'b1;
          if (&clr_addr_q) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end
        end
        StRun: begin
          init_done_q <= 1'b1;
          if (accept) begin
            csb_q   <= 1'b0;
            web_q   <= ~sel_we;
            wmask_q <= sel_we ? sel_wmask : '0;
            addr_q  <= sel_addr;
            din_q   <= sel_wdata;
            // Next tie goes to whichever side was not just served
            ptr_q   <= grant_a;
          end else begin
            csb_q   <= 1'b1;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign a_req_ready = grant_a;
  assign b_req_ready = grant_b;
  assign a_rsp_valid = a_rsp_valid_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign init_done   = init_done_q;
  assign sram_csb0   = csb_q;
  assign sram_web0   = web_q;
  assign sram_wmask0 = wmask_q;
  assign sram_addr0  = addr_q;
  assign sram_din0   = din_q;

endmodule

// File: tb/tb_sram_rw_port_arbiter.sv
// Directed bench for sram_rw_port_arbiter with a behavioural OpenRAM port model.
module tb_sram_rw_port_arbiter;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_req_valid, a_req_ready, a_req_we;
  logic [MW-1:0] a_req_wmask;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata;
  logic          b_req_valid, b_req_ready, b_req_we;
  logic [MW-1:0] b_req_wmask;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata;
  logic          a_rsp_valid, b_rsp_valid, init_done;
  logic [DW-1:0] rsp_rdata;
  logic          sram_csb0, sram_web0;
  logic [MW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0, sram_dout0;

  always #5 clk = ~clk;

  sram_rw_port_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_WMASKS(MW), .CLEAR_ON_RESET(1)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_wmask(a_req_wmask), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_wmask(b_req_wmask), .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata),
    .a_rsp_valid(a_rsp_valid), .b_rsp_valid(b_rsp_valid), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // OpenRAM-style port: inputs latched at posedge, array access at negedge
  logic [DW-1:0] mem [256];
  logic          csb_r = 1'b1, web_r = 1'b1;
  logic [MW-1:0] wm_r = '0;
  logic [AW-1:0] ad_r = '0;
  logic [DW-1:0] di_r = '0;

  initial begin
    sram_dout0 = '0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h1;
  end

  always @(posedge clk) begin
    csb_r <= sram_csb0;
    web_r <= sram_web0;
    wm_r  <= sram_wmask0;
    ad_r  <= sram_addr0;
    di_r  <= sram_din0;
  end

  always @(negedge clk) begin
    if (!csb_r) begin
      if (!web_r) begin
        for (int b = 0; b < MW; b++)
          if (wm_r[b]) mem[ad_r][b*8 +: 8] <= di_r[b*8 +: 8];
      end else begin
        sram_dout0 <= mem[ad_r];
      end
    end
  end

  // Cycle counter and response/ready monitor
  int unsigned   cyc_cnt = 0;
  bit            rsp_id_q[$];
  logic [DW-1:0] rsp_data_q[$];
  int unsigned   rsp_cyc_q[$];
  int            both_ready = 0;
  int            both_rsp = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (a_rsp_valid) begin
      rsp_id_q.push_back(1'b0); rsp_data_q.push_back(rsp_rdata); rsp_cyc_q.push_back(cyc_cnt);
    end
    if (b_rsp_valid) begin
      rsp_id_q.push_back(1'b1); rsp_data_q.push_back(rsp_rdata); rsp_cyc_q.push_back(cyc_cnt);
    end
    if (a_rsp_valid && b_rsp_valid) both_rsp++;
    if (a_req_ready && b_req_ready) both_ready++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush();
    rsp_id_q.delete();
    rsp_data_q.delete();
    rsp_cyc_q.delete();
  endtask

  // Present one request from post-edge, wait for ready, return accept cycle
  task automatic do_req(input bit side, input bit we, input logic [MW-1:0] m,
                        input logic [AW-1:0] ad, input logic [DW-1:0] d,
                        output int unsigned acc);
    int n = 0;
    if (!side) begin
      a_req_valid = 1; a_req_we = we; a_req_wmask = m; a_req_addr = ad; a_req_wdata = d;
    end else begin
      b_req_valid = 1; b_req_we = we; b_req_wmask = m; b_req_addr = ad; b_req_wdata = d;
    end
    @(negedge clk);
    while (!(side ? b_req_ready : a_req_ready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check(side ? "b_req_ready" : "a_req_ready", side ? b_req_ready : a_req_ready, 1);
    @(posedge clk);
    #1;
    acc = cyc_cnt;
    if (!side) a_req_valid = 0; else b_req_valid = 0;
  endtask

  // Wait for init_done with both requesters pushing reads; returns on the rising cycle
  task automatic wait_sweep(input string tag);
    int n = 0;
    int rdy = 0;
    logic [31:0] first_ctl = '1;
    logic [7:0]  last_addr = '0;
    a_req_valid = 1; a_req_we = 0; a_req_addr = 8'h00;
    b_req_valid = 1; b_req_we = 0; b_req_addr = 8'h00;
    while (!init_done && n < 400) begin
      tick();
      n++;
      if (!init_done && (a_req_ready || b_req_ready)) rdy++;
      if (n == 1) first_ctl = {14'd0, sram_csb0, sram_web0, sram_wmask0, sram_addr0, 4'd0};
      if (n == 256) last_addr = sram_addr0;
    end
    a_req_valid = 0;
    b_req_valid = 0;
    check({tag, "_len"}, n, 256);
    check({tag, "_ready"}, rdy, 0);
    check({tag, "_first"}, first_ctl, {14'd0, 1'b0, 1'b0, 4'hF, 8'h00, 4'd0});
    check({tag, "_last_addr"}, last_addr, 8'hFF);
  endtask

  int unsigned acc, acc0;
  int          bad;

  initial begin
    #400_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    a_req_valid = 0; a_req_we = 0; a_req_wmask = '0; a_req_addr = '0; a_req_wdata = '0;
    b_req_valid = 0; b_req_we = 0; b_req_wmask = '0; b_req_addr = '0; b_req_wdata = '0;
    repeat (3) tick();

    // Reset values
    check("rst_csb0", sram_csb0, 1);
    check("rst_web0", sram_web0, 1);
    check("rst_wmask0", sram_wmask0, 0);
    check("rst_addr0", sram_addr0, 0);
    check("rst_din0", sram_din0, 0);
    check("rst_readys", {a_req_ready, b_req_ready}, 0);
    check("rst_rsp", {a_rsp_valid, b_rsp_valid}, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_init_done", init_done, 0);

    // Sweep, then read back all 256 words as zero
    rst = 0;
    wait_sweep("sweep1");
    flush();
    for (int i = 0; i < 256; i++) do_req(0, 0, 4'h0, i[7:0], 32'h0, acc);
    repeat (4) tick();
    bad = 0;
    foreach (rsp_data_q[i]) if (rsp_data_q[i] !== 32'h0 || rsp_id_q[i] !== 1'b0) bad++;
    check("clear_rsp_count", rsp_data_q.size(), 256);
    check("clear_nonzero", bad, 0);

    // A write then A read of 0x10
    flush();
    do_req(0, 1, 4'hF, 8'h10, 32'hDEADBEEF, acc);
    check("wr_ctl", {sram_csb0, sram_web0, sram_wmask0, sram_addr0}, {1'b0, 1'b0, 4'hF, 8'h10});
    check("wr_din", sram_din0, 32'hDEADBEEF);
    do_req(0, 0, 4'hF, 8'h10, 32'h0, acc);
    check("rd_ctl", {sram_csb0, sram_web0, sram_wmask0, sram_addr0}, {1'b0, 1'b1, 4'h0, 8'h10});
    tick();
    check("idle_csb0", sram_csb0, 1);
    repeat (4) tick();
    check("wr_rd_count", rsp_data_q.size(), 1);
    if (rsp_data_q.size() == 1) begin
      check("wr_rd_data", rsp_data_q[0], 32'hDEADBEEF);
      check("wr_rd_id", rsp_id_q[0], 0);
      check("wr_rd_latency", rsp_cyc_q[0] - acc, 2);
    end

    // B byte-masked writes to 0x20
    flush();
    do_req(1, 1, 4'hF, 8'h20, 32'h11223344, acc);
    do_req(1, 1, 4'h5, 8'h20, 32'hAABBCCDD, acc);
    do_req(1, 0, 4'h0, 8'h20, 32'h0, acc);
    repeat (4) tick();
    check("mask_count", rsp_data_q.size(), 1);
    if (rsp_data_q.size() == 1) begin
      check("mask_data", rsp_data_q[0], 32'h11BB33DD);
      check("mask_id", rsp_id_q[0], 1);
      check("mask_latency", rsp_cyc_q[0] - acc, 2);
    end

    // Contention: last grant was B, so the pointer favours A
    do_req(0, 1, 4'hF, 8'h01, 32'hA1A1A1A1, acc);
    do_req(1, 1, 4'hF, 8'h02, 32'hB2B2B2B2, acc);
    flush();
    a_req_valid = 1; a_req_we = 0; a_req_addr = 8'h01;
    b_req_valid = 1; b_req_we = 0; b_req_addr = 8'h02;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("grant_%0d", k), {a_req_ready, b_req_ready}, (k % 2 == 0) ? 2'b10 : 2'b01);
      tick();
    end
    a_req_valid = 0;
    b_req_valid = 0;
    repeat (4) tick();
    check("rr_count", rsp_data_q.size(), 4);
    if (rsp_data_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("rr_id_%0d", k), rsp_id_q[k], k % 2);
        check($sformatf("rr_data_%0d", k), rsp_data_q[k],
              (k % 2 == 0) ? 32'hA1A1A1A1 : 32'hB2B2B2B2);
      end
    end

    // Eight back-to-back A reads
    for (int i = 0; i < 8; i++) do_req(0, 1, 4'hF, i[7:0], 32'h7000_0000 + i * 32'h111, acc);
    flush();
    for (int i = 0; i < 8; i++) begin
      do_req(0, 0, 4'h0, i[7:0], 32'h0, acc);
      if (i == 0) acc0 = acc;
    end
    repeat (4) tick();
    check("b2b_count", rsp_data_q.size(), 8);
    if (rsp_data_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("b2b_data_%0d", i), rsp_data_q[i], 32'h7000_0000 + i * 32'h111);
        check($sformatf("b2b_cyc_%0d", i), rsp_cyc_q[i] - acc0, 2 + i);
      end
    end
    check("both_ready", both_ready, 0);
    check("both_rsp", both_rsp, 0);

    // Reset at sweep address 100
    rst = 1;
    tick();
    rst = 0;
    repeat (101) tick();
    check("mid_addr", sram_addr0, 8'd100);
    check("mid_csb0", sram_csb0, 0);
    rst = 1;
    tick();
    check("mid_rst_ctl", {sram_csb0, sram_web0, sram_wmask0, sram_addr0}, {1'b1, 1'b1, 4'h0, 8'h00});
    check("mid_rst_init", init_done, 0);
    rst = 0;
    wait_sweep("sweep2");

    // Reset with two reads in flight
    flush();
    do_req(0, 0, 4'h0, 8'h05, 32'h0, acc);
    do_req(0, 0, 4'h0, 8'h06, 32'h0, acc);
    rst = 1;
    tick();
    check("fl_rst_csb0", sram_csb0, 1);
    check("fl_rst_rsp", {a_rsp_valid, b_rsp_valid}, 0);
    rst = 0;
    wait_sweep("sweep3");
    check("fl_rsp_count", rsp_data_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
